mem_op_sequencer: RTL and testbench

- Multi-cycle back end that executes the memory-touching operations flagged by the instruction decoder: lw, sw, jmem, bmem and js.
- Accepts one decoded operation per start pulse and drives a req/ack data-memory bus.
- Returns a register writeback value and/or a PC redirect to the datapath.
- Sits between the decode stage and data memory; the datapath stalls while busy is high.

---
 rtl/mem_op_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_op_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_op_sequencer.sv
// Multi-cycle executor for memory-touching ops (lw, sw, jmem, bmem, js).
// Drives a registered req/ack data bus and returns writeback / PC redirect results.
module mem_op_sequencer #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          op_lw,
  input  logic          op_sw,
  input  logic          op_jmem,
  input  logic          op_bmem,
  input  logic          op_js,
  input  logic          cond,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] pcplus4,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          done,
  output logic          wb_en,
  output logic [DW-1:0] wb_data,
  output logic          pc_load,
  output logic [DW-1:0] pc_next,
  output logic          err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam int unsigned NOP     = 5;
  localparam int unsigned OP_JS   = 0;
  localparam int unsigned OP_BMEM = 1;
  localparam int unsigned OP_JMEM = 2;
  localparam int unsigned OP_SW   = 3;
  localparam int unsigned OP_LW   = 4;

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  // Legal decode means exactly one op flag set.
  function automatic logic op_illegal(input logic [NOP-1:0] v);
    return (v == '0) || ((v & (v - NOP'(1))) != '0);
  endfunction

  logic [1:0]     state_q, state_d;
  logic [NOP-1:0] op_q, op_d;
  logic [DW-1:0]  link_q, link_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mem_req_q, mem_req_d;
  logic           mem_we_q, mem_we_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           wb_en_q, wb_en_d;
  logic [DW-1:0]  wb_data_q, wb_data_d;
  logic           pc_load_q, pc_load_d;
  logic [DW-1:0]  pc_next_q, pc_next_d;
  logic           err_q, err_d;

  logic [NOP-1:0] in_op_c;
  logic           ack_c;

  assign in_op_c = {op_lw, op_sw, op_jmem, op_bmem, op_js};
  assign ack_c   = mem_ack & mem_req_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    link_d      = link_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_data_d   = wb_data_q;
    pc_next_d   = pc_next_q;
    done_d      = 1'b0;
    wb_en_d     = 1'b0;
    pc_load_d   = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d        = in_op_c;
          link_d      = pcplus4;
          mem_addr_d  = addr;
          mem_wdata_d = wdata;
          cnt_d       = '0;
          if (op_illegal(in_op_c) || (op_bmem && !cond)) begin
            state_d = S_FIN;
          end else if (op_sw) begin
            state_d   = S_WR;
            mem_req_d = 1'b1;
            mem_we_d  = 1'b1;
          end else begin
            state_d   = S_RD;
            mem_req_d = 1'b1;
            mem_we_d  = 1'b0;
          end
        end
      end

      S_RD: begin
        if (ack_c) begin
          mem_req_d = 1'b0;
          rdata_d   = mem_rdata;
          cnt_d     = '0;
          if (op_q[OP_JS]) begin
            // Request stays low for one cycle before the link write goes out.
            state_d     = S_WR;
            mem_we_d    = 1'b1;
            mem_wdata_d = link_q;
          end else begin
            state_d = S_FIN;
            done_d  = 1'b1;
            if (op_q[OP_LW]) begin
              wb_en_d   = 1'b1;
              wb_data_d = mem_rdata;
            end else begin
              pc_load_d = 1'b1;
              pc_next_d = mem_rdata;
            end
          end
        end else if (mem_req_q && (cnt_q == CNT_LAST)) begin
          mem_req_d = 1'b0;
          state_d   = S_FIN;
          done_d    = 1'b1;
          err_d     = 1'b1;
        end else if (mem_req_q) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_WR: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (ack_c) begin
          mem_req_d = 1'b0;
          state_d   = S_FIN;
          done_d    = 1'b1;
          if (op_q[OP_JS]) begin
            pc_load_d = 1'b1;
            pc_next_d = rdata_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          state_d   = S_FIN;
          done_d    = 1'b1;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_FIN: begin
        // Bus ops enter FIN with done already raised; decode-only ops raise it here.
        if (done_q) begin
          state_d = S_IDLE;
        end else begin
          done_d = 1'b1;
          err_d  = op_illegal(op_q);
        end
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      link_q      <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_data_q   <= '0;
      pc_load_q   <= 1'b0;
      pc_next_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      link_q      <= link_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wb_en_q     <= wb_en_d;
      wb_data_q   <= wb_data_d;
      pc_load_q   <= pc_load_d;
      pc_next_q   <= pc_next_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wb_en     = wb_en_q;
  assign wb_data   = wb_data_q;
  assign pc_load   = pc_load_q;
  assign pc_next   = pc_next_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Self-checking bench for mem_op_sequencer: vector table, memory responder, done scoreboard.
module tb_mem_op_sequencer;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 15;

  localparam logic [4:0] OP_LW   = 5'b10000;
  localparam logic [4:0] OP_SW   = 5'b01000;
  localparam logic [4:0] OP_JMEM = 5'b00100;
  localparam logic [4:0] OP_BMEM = 5'b00010;
  localparam logic [4:0] OP_JS   = 5'b00001;

  logic          clk, reset, start;
  logic          op_lw, op_sw, op_jmem, op_bmem, op_js, cond;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, pcplus4;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
  logic          busy, done, wb_en, pc_load, err;
  logic [DW-1:0] wb_data, pc_next;

  mem_op_sequencer #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .op_lw(op_lw), .op_sw(op_sw), .op_jmem(op_jmem), .op_bmem(op_bmem), .op_js(op_js),
    .cond(cond), .addr(addr), .wdata(wdata), .pcplus4(pcplus4),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .wb_en(wb_en), .wb_data(wb_data),
    .pc_load(pc_load), .pc_next(pc_next), .err(err)
  );

  typedef struct {
    logic [4:0]  ops;
    logic        cond;
    logic [31:0] addr, wdata, pc4, mem0;
    int          k;
    bit          never;
    logic        wb_en, pc_load, err;
    logic [31:0] wb_data, pc_next;
    int          lat, nrd, nwr, reqhi;
    bit          memchk;
    logic [31:0] memafter;
  } vec_t;

  typedef struct {
    logic        wb_en, pc_load, err;
    logic [31:0] wb_data, pc_next;
    int          lat, t0;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr, data;
    int          rise, ack;
    bit          stable;
  } bus_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int resp_k = 1;
  bit resp_never = 0;
  bit spur = 0;
  int rq = 0;
  int req_hi = 0;
  bus_t cur;
  exp_t sbq[$];
  bus_t blog[$];
  logic [31:0] mem [logic [31:0]];
  vec_t vt[15];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mkv(input logic [4:0] ops, input logic c, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] p4, input logic [31:0] m0,
                               input int k, input bit nev, input logic wbe, input logic pl,
                               input logic er, input int lat, input int nrd, input int nwr,
                               input int rh, input bit mc, input logic [31:0] ma);
    vec_t v;
    v.ops = ops; v.cond = c; v.addr = a; v.wdata = wd; v.pc4 = p4; v.mem0 = m0;
    v.k = k; v.never = nev; v.wb_en = wbe; v.pc_load = pl; v.err = er;
    v.wb_data = m0; v.pc_next = m0;
    v.lat = lat; v.nrd = nrd; v.nwr = nwr; v.reqhi = rh; v.memchk = mc; v.memafter = ma;
    return v;
  endfunction

  // Memory responder: acks on the (k+1)-th cycle of a request, logs completed accesses.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (rq == 0) begin
          cur.rise = cyc; cur.we = mem_we; cur.addr = mem_addr; cur.data = mem_wdata; cur.stable = 1'b1;
        end else if (mem_we !== cur.we || mem_addr !== cur.addr || mem_wdata !== cur.data) begin
          cur.stable = 1'b0;
        end
        rq++;
        req_hi++;
        if (!resp_never && rq == resp_k + 1) begin
          mem_ack = 1'b1;
          cur.ack = cyc;
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
          end else begin
            mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
            cur.data = mem_rdata;
          end
          blog.push_back(cur);
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        rq = 0;
        mem_ack = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = $urandom;
      end
    end
  end

  // Completion monitor: pops the scoreboard on every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        if (sbq.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("latency", 64'(cyc - e.t0), 64'(e.lat));
          chk("wb_en", 64'(wb_en), 64'(e.wb_en));
          if (e.wb_en) chk("wb_data", 64'(wb_data), 64'(e.wb_data));
          chk("pc_load", 64'(pc_load), 64'(e.pc_load));
          if (e.pc_load) chk("pc_next", 64'(pc_next), 64'(e.pc_next));
          chk("err", 64'(err), 64'(e.err));
        end
      end else begin
        chk("flags_without_done", 64'({wb_en, pc_load, err}), 64'd0);
      end
    end
  end

  task automatic drive_start(input logic [4:0] ops, input logic c, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] p4);
    {op_lw, op_sw, op_jmem, op_bmem, op_js} = ops;
    cond = c; addr = a; wdata = wd; pcplus4 = p4;
    start = 1'b1;
  endtask

  task automatic scramble_inputs();
    start = 1'b0;
    {op_lw, op_sw, op_jmem, op_bmem, op_js} = 5'($urandom);
    cond = 1'($urandom); addr = $urandom; wdata = $urandom; pcplus4 = $urandom;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int t = 0; t < budget && done_cnt == d0; t++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int d0, nr, nw, ir, iw;
    blog.delete();
    resp_k = v.k;
    resp_never = v.never;
    mem[v.addr] = v.mem0;
    d0 = done_cnt;
    @(posedge clk);
    #2;
    req_hi = 0;
    drive_start(v.ops, v.cond, v.addr, v.wdata, v.pc4);
    e.wb_en = v.wb_en; e.wb_data = v.wb_data; e.pc_load = v.pc_load;
    e.pc_next = v.pc_next; e.err = v.err; e.lat = v.lat; e.t0 = cyc;
    sbq.push_back(e);
    @(posedge clk);
    #2;
    scramble_inputs();
    chk($sformatf("v%0d_busy_after_start", idx), 64'(busy), 64'd1);
    wait_done(d0, 60);
    chk($sformatf("v%0d_done_count", idx), 64'(done_cnt - d0), 64'd1);
    sbq.delete();
    @(posedge clk);
    #2;
    chk($sformatf("v%0d_busy_after_done", idx), 64'(busy), 64'd0);
    nr = 0; nw = 0; ir = -1; iw = -1;
    foreach (blog[i]) begin
      if (blog[i].we) begin nw++; iw = i; end else begin nr++; ir = i; end
      chk($sformatf("v%0d_bus_stable", idx), 64'(blog[i].stable), 64'd1);
      chk($sformatf("v%0d_bus_addr", idx), 64'(blog[i].addr), 64'(v.addr));
      if (blog[i].we)
        chk($sformatf("v%0d_bus_wdata", idx), 64'(blog[i].data),
            64'((v.ops == OP_JS) ? v.pc4 : v.wdata));
    end
    chk($sformatf("v%0d_reads", idx), 64'(nr), 64'(v.nrd));
    chk($sformatf("v%0d_writes", idx), 64'(nw), 64'(v.nwr));
    chk($sformatf("v%0d_req_cycles", idx), 64'(req_hi), 64'(v.reqhi));
    if (ir >= 0 && iw >= 0)
      chk($sformatf("v%0d_js_gap", idx), 64'(blog[iw].rise - blog[ir].ack >= 2), 64'd1);
    if (v.memchk)
      chk($sformatf("v%0d_mem_after", idx), 64'(mem[v.addr]), 64'(v.memafter));
  endtask

  initial begin
    exp_t e;
    int d0;
    reset = 1'b1;
    scramble_inputs();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wb", 64'({wb_en, wb_data}), 64'd0);
    chk("rst_pc", 64'({pc_load, pc_next}), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    spur = 1'b1;
    repeat (2) @(posedge clk);

    //          ops              c  addr        wdata         pc4        mem0          k  nev wb pl er lat rd wr rh mc memafter
    vt[0]  = mkv(OP_LW,          0, 32'h40,  32'h0,        32'h0,   32'hDEADBEEF,  1, 0, 1, 0, 0,  3, 1, 0, 2, 0, 32'h0);
    vt[1]  = mkv(OP_SW,          0, 32'h10,  32'h12345678, 32'h0,   32'h0,         3, 0, 0, 0, 0,  5, 0, 1, 4, 1, 32'h12345678);
    vt[2]  = mkv(OP_JS,          0, 32'h80,  32'h0,        32'h104, 32'h400,       1, 0, 0, 1, 0,  6, 1, 1, 4, 1, 32'h104);
    vt[3]  = mkv(OP_BMEM,        0, 32'h200, 32'h0,        32'h0,   32'h2000,      1, 0, 0, 0, 0,  2, 0, 0, 0, 0, 32'h0);
    vt[4]  = mkv(OP_BMEM,        1, 32'h200, 32'h0,        32'h0,   32'h2000,      2, 0, 0, 1, 0,  4, 1, 0, 3, 0, 32'h0);
    vt[5]  = mkv(OP_JMEM,        0, 32'h300, 32'h0,        32'h0,   32'h1234,      1, 1, 0, 0, 1, 16, 0, 0, 15, 0, 32'h0);
    vt[6]  = mkv(OP_LW | OP_SW,  0, 32'h20,  32'h0,        32'h0,   32'h0,         1, 0, 0, 0, 1,  2, 0, 0, 0, 0, 32'h0);
    vt[7]  = mkv(5'b00000,       1, 32'h24,  32'h0,        32'h0,   32'h0,         1, 0, 0, 0, 1,  2, 0, 0, 0, 0, 32'h0);
    vt[8]  = mkv(OP_JMEM,        0, 32'h304, 32'h0,        32'h0,   32'hCAFE0000,  2, 0, 0, 1, 0,  4, 1, 0, 3, 0, 32'h0);
    vt[9]  = mkv(OP_JS,          0, 32'h84,  32'h0,        32'h208, 32'h555,       3, 0, 0, 1, 0, 10, 1, 1, 8, 1, 32'h208);
    vt[10] = mkv(OP_LW,          0, 32'h44,  32'h0,        32'h0,   32'h0A0B0C0D, 14, 0, 1, 0, 0, 16, 1, 0, 15, 0, 32'h0);
    vt[11] = mkv(OP_LW,          0, 32'h48,  32'h0,        32'h0,   32'h77,       15, 0, 0, 0, 1, 16, 0, 0, 15, 0, 32'h0);
    vt[12] = mkv(OP_JS,          0, 32'h88,  32'h0,        32'h10C, 32'h999,       1, 1, 0, 0, 1, 16, 0, 0, 15, 1, 32'h999);
    vt[13] = mkv(OP_SW,          0, 32'h14,  32'hA5A5A5A5, 32'h0,   32'h0,         1, 0, 0, 0, 0,  3, 0, 1, 2, 1, 32'hA5A5A5A5);
    vt[14] = mkv(OP_JMEM | OP_JS, 0, 32'h28, 32'h0,        32'h0,   32'h0,         1, 0, 0, 0, 1,  2, 0, 0, 0, 0, 32'h0);

    for (int i = 0; i < 15; i++) run_vec(vt[i], i);

    // Reset during the write phase of a js: no done, write never completes.
    blog.delete();
    mem[32'h90] = 32'h77;
    resp_k = 3;
    resp_never = 1'b0;
    d0 = done_cnt;
    @(posedge clk);
    #2;
    drive_start(OP_JS, 1'b0, 32'h90, 32'h0, 32'h500);
    @(posedge clk);
    #2;
    scramble_inputs();
    for (int t = 0; t < 40 && !(mem_req && mem_we); t++) begin
      @(posedge clk);
      #2;
    end
    chk("rstjs_reached_write", 64'(mem_req && mem_we), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("rstjs_mem_req", 64'(mem_req), 64'd0);
    chk("rstjs_busy_done", 64'({busy, done}), 64'd0);
    chk("rstjs_bus", 64'({mem_we, mem_addr}), 64'd0);
    chk("rstjs_results", 64'({wb_en, pc_load, err}), 64'd0);
    chk("rstjs_pc_next", 64'(pc_next), 64'd0);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("rstjs_no_done", 64'(done_cnt - d0), 64'd0);
    chk("rstjs_mem_kept", 64'(mem[32'h90]), 64'h77);
    chk("rstjs_only_read", 64'(blog.size()), 64'd1);

    // A start while busy is dropped: one lw completes, the sw never runs.
    blog.delete();
    mem[32'h4C] = 32'h11112222;
    resp_k = 2;
    d0 = done_cnt;
    @(posedge clk);
    #2;
    drive_start(OP_LW, 1'b0, 32'h4C, 32'h0, 32'h0);
    e.wb_en = 1'b1; e.wb_data = 32'h11112222; e.pc_load = 1'b0; e.pc_next = 32'h0;
    e.err = 1'b0; e.lat = 4; e.t0 = cyc;
    sbq.push_back(e);
    @(posedge clk);
    #2;
    scramble_inputs();
    @(posedge clk);
    #2;
    drive_start(OP_SW, 1'b0, 32'h50, 32'h99, 32'h0);
    @(posedge clk);
    #2;
    scramble_inputs();
    wait_done(d0, 60);
    repeat (20) @(posedge clk);
    #2;
    chk("busy_start_one_done", 64'(done_cnt - d0), 64'd1);
    chk("busy_start_one_access", 64'(blog.size()), 64'd1);
    if (blog.size() > 0) chk("busy_start_was_read", 64'(blog[0].we), 64'd0);
    chk("busy_start_no_write", 64'(mem.exists(32'h50)), 64'd0);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
